// File: rtl/translate_axi_burst.sv
// Bridges line-read and single-beat write requests onto an AXI4 master port; read beats are registered, hold under STALL.
// Optional sticky response/early-RLAST error flag is built only when TRANSLATE_AXI_RESP_CHECK_EN is defined.
module translate_axi_burst #(
   parameter int DATA_WIDTH = 32,
   parameter int BURST_LEN  = 4,
   parameter int ADDR_WIDTH = 32
) (
   input  logic                    CLK,
   input  logic                    RST,
   input  logic                    STALL,
   output logic                    BUSY,
   input  logic                    RREQ,
   input  logic [ADDR_WIDTH-1:0]   RADDR,
   output logic                    RVALID,
   output logic [DATA_WIDTH-1:0]   RDATA,
   output logic [3:0]              RBEAT,
   output logic                    RLAST,
   input  logic                    WREQ,
   input  logic [ADDR_WIDTH-1:0]   WADDR,
   input  logic [DATA_WIDTH/8-1:0] WSTRB,
   input  logic [DATA_WIDTH-1:0]   WDATA,
   output logic                    WDONE,
   output logic                    ERR,
   output logic [ADDR_WIDTH-1:0]   M_AXI_AWADDR,
   output logic [7:0]              M_AXI_AWLEN,
   output logic [2:0]              M_AXI_AWSIZE,
   output logic [1:0]              M_AXI_AWBURST,
   output logic                    M_AXI_AWVALID,
   input  logic                    M_AXI_AWREADY,
   output logic [DATA_WIDTH-1:0]   M_AXI_WDATA,
   output logic [DATA_WIDTH/8-1:0] M_AXI_WSTRB,
   output logic                    M_AXI_WLAST,
   output logic                    M_AXI_WVALID,
   input  logic                    M_AXI_WREADY,
   input  logic [1:0]              M_AXI_BRESP,
   input  logic                    M_AXI_BVALID,
   output logic                    M_AXI_BREADY,
   output logic [ADDR_WIDTH-1:0]   M_AXI_ARADDR,
   output logic [7:0]              M_AXI_ARLEN,
   output logic [2:0]              M_AXI_ARSIZE,
   output logic [1:0]              M_AXI_ARBURST,
   output logic                    M_AXI_ARVALID,
   input  logic                    M_AXI_ARREADY,
   input  logic [DATA_WIDTH-1:0]   M_AXI_RDATA,
   input  logic [1:0]              M_AXI_RRESP,
   input  logic                    M_AXI_RLAST,
   input  logic                    M_AXI_RVALID,
   output logic                    M_AXI_RREADY
);
   localparam int BYTES = DATA_WIDTH / 8;
   localparam int OFF_W = $clog2(BYTES);
   localparam logic [ADDR_WIDTH-1:0] W_MASK = ~ADDR_WIDTH'(BYTES - 1);
   localparam logic [ADDR_WIDTH-1:0] R_MASK = ~ADDR_WIDTH'(BURST_LEN * BYTES - 1);
   localparam logic [3:0] LAST_IDX = 4'(BURST_LEN - 1);

   localparam logic [1:0] R_IDLE = 2'd0, R_ADDR = 2'd1, R_DATA = 2'd2;
   localparam logic [1:0] W_IDLE = 2'd0, W_REQ = 2'd1, W_RESP = 2'd2;

   logic [1:0]            r_state, w_state;
   logic [ADDR_WIDTH-1:0] ar_addr, aw_addr;
   logic [3:0]            beat_cnt;
   logic                  r_hs, beat_last;
   logic [OFF_W-1:0]      w_off;

   assign w_off     = WADDR[OFF_W-1:0];
   assign beat_last = (beat_cnt == LAST_IDX);
   assign r_hs      = (r_state == R_DATA) && M_AXI_RVALID && !STALL;

   assign M_AXI_ARADDR  = ar_addr;
   assign M_AXI_ARLEN   = 8'(BURST_LEN - 1);
   assign M_AXI_ARSIZE  = 3'(OFF_W);
   assign M_AXI_ARBURST = 2'b01;
   assign M_AXI_ARVALID = (r_state == R_ADDR);
   assign M_AXI_RREADY  = (r_state == R_DATA) && !STALL;

   assign M_AXI_AWADDR  = aw_addr;
   assign M_AXI_AWLEN   = 8'd0;
   assign M_AXI_AWSIZE  = 3'(OFF_W);
   assign M_AXI_AWBURST = 2'b01;
   assign M_AXI_WLAST   = 1'b1;
   assign M_AXI_BREADY  = (w_state == W_RESP);

   // A request counts as busy in the cycle it is accepted, before either FSM has left idle.
   assign BUSY = !RST && ((r_state != R_IDLE) || (w_state != W_IDLE) || RREQ || WREQ);

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state  <= R_IDLE;
         ar_addr  <= '0;
         beat_cnt <= '0;
         RVALID   <= 1'b0;
         RDATA    <= '0;
         RBEAT    <= '0;
         RLAST    <= 1'b0;
      end else begin
         case (r_state)
            R_IDLE: if (RREQ) begin
               ar_addr <= RADDR & R_MASK;
               r_state <= R_ADDR;
            end
            R_ADDR: if (M_AXI_ARREADY) r_state <= R_DATA;
            R_DATA: if (r_hs && M_AXI_RLAST) r_state <= R_IDLE;
            default: r_state <= R_IDLE;
         endcase
         // Early slave RLAST also ends the burst, so the counter restarts either way.
         if (r_hs) begin
            RVALID   <= 1'b1;
            RDATA    <= M_AXI_RDATA;
            RBEAT    <= beat_cnt;
            RLAST    <= beat_last || M_AXI_RLAST;
            beat_cnt <= (beat_last || M_AXI_RLAST) ? 4'd0 : beat_cnt + 4'd1;
         end else if (!STALL) begin
            RVALID <= 1'b0;
            RLAST  <= 1'b0;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         w_state       <= W_IDLE;
         aw_addr       <= '0;
         M_AXI_WDATA   <= '0;
         M_AXI_WSTRB   <= '0;
         M_AXI_AWVALID <= 1'b0;
         M_AXI_WVALID  <= 1'b0;
         WDONE         <= 1'b0;
      end else begin
         WDONE <= 1'b0;
         case (w_state)
            W_IDLE: if (WREQ) begin
               aw_addr       <= WADDR & W_MASK;
               M_AXI_WSTRB   <= WSTRB << w_off;
               M_AXI_WDATA   <= WDATA << {w_off, 3'b000};
               M_AXI_AWVALID <= 1'b1;
               M_AXI_WVALID  <= 1'b1;
               w_state       <= W_REQ;
            end
            W_REQ: begin
               if (M_AXI_AWREADY) M_AXI_AWVALID <= 1'b0;
               if (M_AXI_WREADY)  M_AXI_WVALID  <= 1'b0;
               if ((!M_AXI_AWVALID || M_AXI_AWREADY) && (!M_AXI_WVALID || M_AXI_WREADY))
                  w_state <= W_RESP;
            end
            W_RESP: if (M_AXI_BVALID) begin
               w_state <= W_IDLE;
               WDONE   <= 1'b1;
            end
            default: w_state <= W_IDLE;
         endcase
      end
   end

`ifdef TRANSLATE_AXI_RESP_CHECK_EN
   logic err_q;
   always_ff @(posedge CLK) begin
      if (RST)
         err_q <= 1'b0;
      else if ((r_hs && ((M_AXI_RRESP != 2'b00) || (M_AXI_RLAST && !beat_last))) ||
               ((w_state == W_RESP) && M_AXI_BVALID && (M_AXI_BRESP != 2'b00)))
         err_q <= 1'b1;
   end
   assign ERR = err_q;
`else
   logic unused_resp;
   assign unused_resp = ^{M_AXI_RRESP, M_AXI_BRESP};
   assign ERR = 1'b0;
`endif

endmodule
